debounce_multi: RTL and testbench
=================================

Name: debounce_multi

Overview:
- Parametrised successor to the single-switch chattering cut. Debounces N_CH independent mechanical inputs using one shared sample prescaler.
- Per channel it provides:
  - a clean level;
  - single-cycle rise and fall strobes;
  - a long-press strobe.
- Sits between board push-buttons/switches and control logic such as stopwatch start/stop/lap and mode keys, on the 32 MHz system clock.

Parameters:
- N_CH, 4, number of independent input channels (>=1).
- SAMPLE_DIV, 32000, clk cycles per sample tick (>=2; 32000 = 1 ms at 32 MHz).
- STABLE_CNT, 4, consecutive differing sample ticks required to accept a new level (>=1).
- LONG_CNT, 1000, sample ticks of continuous accepted-high level before long_press fires (0 disables long_press).
- ACTIVE_LOW, 0, 1 = raw input is inverted before debouncing (pressed = 0 on the pin).

Ports:
- clk  in  1  system clock, all logic on rising edge.
- rst  in  1  synchronous, active-high reset.
- sw_in  in  N_CH  raw asynchronous switch inputs.
- sw_out  out  N_CH  debounced level, 1 = pressed/asserted after polarity.
- sw_rise  out  N_CH  one-clk pulse when sw_out goes 0->1.
- sw_fall  out  N_CH  one-clk pulse when sw_out goes 1->0.
- long_press  out  N_CH  one-clk pulse after sw_out held 1 for LONG_CNT ticks.

Behaviour:
- Reset (rst=1 at a clk edge):
  - prescaler = 0;
  - all per-channel counters = 0;
  - sw_out/sw_rise/sw_fall/long_press = 0;
  - synchroniser flops = inactive pin level (0, or 1 when ACTIVE_LOW=1).
  - Reset asserted mid-debounce or mid-hold discards all progress.
  - The first cycle after reset counts as prescaler = 0.
- Synchroniser:
  - two flops per channel on sw_in, then XOR with ACTIVE_LOW to form the sample s[i].
- Prescaler:
  - counts 0..SAMPLE_DIV-1 and wraps;
  - tick = 1 for exactly the cycle where count == SAMPLE_DIV-1;
  - shared by all channels.
- Debounce counter per channel (width clog2(STABLE_CNT+1)), updated only on tick:
  - if s[i] == sw_out[i]: counter = 0.
  - else if counter == STABLE_CNT-1: sw_out[i] toggles, counter = 0, and sw_rise[i] or sw_fall[i] = 1 on the following cycle, matching the new level.
  - else: counter increments.
- Strobes are registered, asserted for exactly one clk, and coincide with the first cycle sw_out shows the new value.
- Latency:
  - a clean step on sw_in reaches sw_out after between 2+(STABLE_CNT-1)*SAMPLE_DIV+1 and 2+STABLE_CNT*SAMPLE_DIV clk;
  - any glitch shorter than STABLE_CNT-1 full tick periods never changes sw_out.
- Hold counter per channel (width clog2(LONG_CNT+1)):
  - cleared whenever sw_out[i] == 0;
  - on tick with sw_out[i] == 1, increments and saturates at LONG_CNT;
  - long_press[i] pulses one clk on the tick where it reaches LONG_CNT;
  - no re-fire until after a fall;
  - a fall before LONG_CNT means no long_press.
- LONG_CNT = 0: long_press is tied to 0.
- Channels are fully independent; simultaneous transitions on several channels each produce their own strobes in the same cycle.
- sw_rise and long_press never coincide on a channel (long_press needs at least one further tick).

Test Plan:
Bench settings: N_CH=2, SAMPLE_DIV=8, STABLE_CNT=3, LONG_CNT=5, ACTIVE_LOW=0, 16 ns clock.
1. Reset, then hold sw_in=2'b00 for 100 clk -> all outputs 0, no strobes.
2. Clean step sw_in[0] 0->1, held -> sw_out[0] rises 19..26 clk after the step.
   - exactly one sw_rise[0] pulse of 1 clk, aligned with the sw_out change;
   - sw_out[1] stays 0.
3. Chatter on ch0: toggle sw_in[0] every 12 clk for 200 clk, then hold 1 -> no sw_out change during the chatter.
   - single sw_rise within 26 clk of the final hold;
   - exactly one sw_rise total.
4. Long press: hold ch1 high for 120 clk after acceptance, then release.
   - long_press[1] pulses once, 5 ticks (40 clk) after sw_rise[1];
   - sw_fall[1] follows the release within 26 clk;
   - second press released after 2 ticks -> no long_press.
5. Simultaneous steps on both channels -> sw_rise=2'b11 in the same cycle.
   - rst pulsed for one clk while ch0 is mid-debounce -> all outputs 0, and acceptance restarts with full latency.
6. Rebuild with ACTIVE_LOW=1, sw_in idle 2'b11 -> sw_out=0 after reset.
   - driving sw_in[0]=0 -> sw_rise[0] and sw_out[0]=1 with the same 19..26 clk latency.

Source files
------------

// File: rtl/debounce_multi.sv
`default_nettype none
// ============================================================================
// Module      : debounce_multi
// Description : N-channel switch debouncer with one shared sample prescaler,
//               per-channel clean level, rise/fall strobes and long-press.
// Revision    : 1.0 - initial release
// ============================================================================
module debounce_multi #(
    parameter int N_CH       = 4,
    parameter int SAMPLE_DIV = 32000,
    parameter int STABLE_CNT = 4,
    parameter int LONG_CNT   = 1000,
    parameter int ACTIVE_LOW = 0
) (
    input  logic            clk,
    input  logic            rst,
    input  logic [N_CH-1:0] sw_in,
    output logic [N_CH-1:0] sw_out,
    output logic [N_CH-1:0] sw_rise,
    output logic [N_CH-1:0] sw_fall,
    output logic [N_CH-1:0] long_press
);

    localparam int c_presc_w = $clog2(SAMPLE_DIV);
    localparam int c_dcnt_w  = $clog2(STABLE_CNT + 1);
    localparam int c_hold_w  = (LONG_CNT > 0) ? $clog2(LONG_CNT + 1) : 1;

    localparam logic [N_CH-1:0]      c_idle       = (ACTIVE_LOW != 0) ? '1 : '0;
    localparam logic [c_presc_w-1:0] c_presc_last = c_presc_w'(SAMPLE_DIV - 1);
    localparam logic [c_dcnt_w-1:0]  c_dcnt_last  = c_dcnt_w'(STABLE_CNT - 1);

    // ------------------------------------------------------------------
    // Two-flop synchroniser; resets to the inactive pin level so that a
    // released switch never looks like a press straight out of reset.
    // ------------------------------------------------------------------
    logic [N_CH-1:0] r_sync1;
    logic [N_CH-1:0] r_sync2;
    logic [N_CH-1:0] w_sample;

    always_ff @(posedge clk) begin
        if (rst) begin
            r_sync1 <= c_idle;
            r_sync2 <= c_idle;
        end else begin
            r_sync1 <= sw_in;
            r_sync2 <= r_sync1;
        end
    end

    assign w_sample = r_sync2 ^ c_idle;

    // ------------------------------------------------------------------
    // Shared sample prescaler
    // ------------------------------------------------------------------
    logic [c_presc_w-1:0] r_presc;
    logic                 w_tick;

    assign w_tick = (r_presc == c_presc_last);

    always_ff @(posedge clk) begin
        if (rst) begin
            r_presc <= '0;
        end else if (w_tick) begin
            r_presc <= '0;
        end else begin
            r_presc <= r_presc + 1'b1;
        end
    end

    // ------------------------------------------------------------------
    // Per-channel debounce and hold tracking
    // ------------------------------------------------------------------
    for (genvar gi = 0; gi < N_CH; gi++) begin : g_ch
        logic [c_dcnt_w-1:0] r_dcnt;
        logic                r_level;
        logic                r_rise;
        logic                r_fall;

        // Strobes are written on the same edge as the level so that they
        // line up with the first cycle the new level is visible.
        always_ff @(posedge clk) begin
            if (rst) begin
                r_dcnt  <= '0;
                r_level <= 1'b0;
                r_rise  <= 1'b0;
                r_fall  <= 1'b0;
            end else begin
                r_rise <= 1'b0;
                r_fall <= 1'b0;
                if (w_tick) begin
                    if (w_sample[gi] == r_level) begin
                        r_dcnt <= '0;
                    end else if (r_dcnt == c_dcnt_last) begin
                        r_dcnt  <= '0;
                        r_level <= ~r_level;
                        r_rise  <= ~r_level;
                        r_fall  <= r_level;
                    end else begin
                        r_dcnt <= r_dcnt + 1'b1;
                    end
                end
            end
        end

        assign sw_out[gi]  = r_level;
        assign sw_rise[gi] = r_rise;
        assign sw_fall[gi] = r_fall;

        if (LONG_CNT > 0) begin : g_long
            localparam logic [c_hold_w-1:0] c_hold_max = c_hold_w'(LONG_CNT);

            logic [c_hold_w-1:0] r_hold;
            logic                r_long;

            // Saturating at the maximum prevents a second pulse until the
            // level drops and clears the count.
            always_ff @(posedge clk) begin
                if (rst) begin
                    r_hold <= '0;
                    r_long <= 1'b0;
                end else begin
                    r_long <= 1'b0;
                    if (!r_level) begin
                        r_hold <= '0;
                    end else if (w_tick && (r_hold != c_hold_max)) begin
                        r_hold <= r_hold + 1'b1;
                        if (r_hold == (c_hold_max - 1'b1)) begin
                            r_long <= 1'b1;
                        end
                    end
                end
            end

            assign long_press[gi] = r_long;
        end else begin : g_no_long
            assign long_press[gi] = 1'b0;
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_debounce_multi.sv
`default_nettype none
// ============================================================================
// Module      : tb_debounce_multi
// Description : Self-checking bench for debounce_multi against a tick-level
//               behavioural model, with directed and randomised stimulus.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_debounce_multi;

    localparam int N_CH       = 2;
    localparam int SAMPLE_DIV = 8;
    localparam int STABLE_CNT = 3;
    localparam int LONG_CNT   = 5;
    localparam int LAT_MIN    = 2 + (STABLE_CNT - 1) * SAMPLE_DIV + 1;
    localparam int LAT_MAX    = 2 + STABLE_CNT * SAMPLE_DIV;

    logic            clk = 1'b0;
    logic            rst;
    logic [N_CH-1:0] sw_in;
    logic [N_CH-1:0] sw_out, sw_rise, sw_fall, long_press;
    logic [N_CH-1:0] sw_in_n;
    logic [N_CH-1:0] sw_out_n, sw_rise_n, sw_fall_n, long_press_n;

    int n_checks = 0;
    int n_errors = 0;

    always #8 clk = ~clk;

    debounce_multi #(
        .N_CH(N_CH), .SAMPLE_DIV(SAMPLE_DIV), .STABLE_CNT(STABLE_CNT),
        .LONG_CNT(LONG_CNT), .ACTIVE_LOW(0)
    ) u_dut (
        .clk(clk), .rst(rst), .sw_in(sw_in), .sw_out(sw_out),
        .sw_rise(sw_rise), .sw_fall(sw_fall), .long_press(long_press)
    );

    debounce_multi #(
        .N_CH(N_CH), .SAMPLE_DIV(SAMPLE_DIV), .STABLE_CNT(STABLE_CNT),
        .LONG_CNT(LONG_CNT), .ACTIVE_LOW(1)
    ) u_dut_n (
        .clk(clk), .rst(rst), .sw_in(sw_in_n), .sw_out(sw_out_n),
        .sw_rise(sw_rise_n), .sw_fall(sw_fall_n), .long_press(long_press_n)
    );

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s got=%0h exp=%0h at %0t", tag, got, exp, $time);
        end
    endtask

    // Reference model: pin history, sample-phase count, and per-channel
    // counts of consecutive disagreeing ticks and ticks held high.
    logic [N_CH-1:0] m_pin_1, m_pin_2;
    int              m_phase;
    logic [N_CH-1:0] m_level, m_rise, m_fall, m_long;
    int              m_diff [N_CH];
    int              m_held [N_CH];

    task automatic model_edge();
        logic [N_CH-1:0] s;
        logic            tick;
        m_rise = '0;
        m_fall = '0;
        m_long = '0;
        if (rst) begin
            m_pin_1 = '0;
            m_pin_2 = '0;
            m_phase = 0;
            m_level = '0;
            for (int c = 0; c < N_CH; c++) begin
                m_diff[c] = 0;
                m_held[c] = 0;
            end
        end else begin
            tick    = (m_phase == SAMPLE_DIV - 1);
            m_phase = (m_phase + 1) % SAMPLE_DIV;
            s       = m_pin_2;
            m_pin_2 = m_pin_1;
            m_pin_1 = sw_in;
            for (int c = 0; c < N_CH; c++) begin
                if (!m_level[c]) m_held[c] = 0;
                if (tick) begin
                    if (m_level[c] && m_held[c] < LONG_CNT) begin
                        m_held[c]++;
                        if (m_held[c] == LONG_CNT) m_long[c] = 1'b1;
                    end
                    if (s[c] != m_level[c]) begin
                        m_diff[c]++;
                        if (m_diff[c] == STABLE_CNT) begin
                            m_diff[c]  = 0;
                            m_level[c] = ~m_level[c];
                            if (m_level[c]) m_rise[c] = 1'b1;
                            else            m_fall[c] = 1'b1;
                        end
                    end else begin
                        m_diff[c] = 0;
                    end
                end
            end
        end
    endtask

    int   rise_cnt [N_CH];
    int   fall_cnt [N_CH];
    int   long_cnt [N_CH];
    logic n_idle;

    task automatic clear_counts();
        for (int c = 0; c < N_CH; c++) begin
            rise_cnt[c] = 0;
            fall_cnt[c] = 0;
            long_cnt[c] = 0;
        end
    endtask

    task automatic cycle();
        @(posedge clk);
        model_edge();
        @(negedge clk);
        check_eq("sw_out", sw_out, m_level);
        check_eq("sw_rise", sw_rise, m_rise);
        check_eq("sw_fall", sw_fall, m_fall);
        check_eq("long_press", long_press, m_long);
        if (n_idle) begin
            check_eq("n_idle_out", {sw_out_n, sw_rise_n, sw_fall_n, long_press_n}, 0);
        end
        for (int c = 0; c < N_CH; c++) begin
            if (sw_rise[c] === 1'b1)    rise_cnt[c]++;
            if (sw_fall[c] === 1'b1)    fall_cnt[c]++;
            if (long_press[c] === 1'b1) long_cnt[c]++;
        end
    endtask

    task automatic wait_level(input int ch, input logic val, output int n);
        n = 0;
        do begin
            cycle();
            n++;
        end while (sw_out[ch] !== val && n < 60);
        check_eq("strobe_align", val ? sw_rise[ch] : sw_fall[ch], 1);
    endtask

    initial begin
        int lat;
        int long_at;

        rst     = 1'b1;
        sw_in   = '0;
        sw_in_n = '1;
        n_idle  = 1'b1;
        clear_counts();
        repeat (3) cycle();
        check_eq("rst_state", {sw_out, sw_rise, sw_fall, long_press}, 0);
        rst = 1'b0;

        // 1: idle
        repeat (100) cycle();
        check_eq("idle_strobes", rise_cnt[0] + rise_cnt[1] + fall_cnt[0] + fall_cnt[1], 0);

        // 2: clean step on ch0
        clear_counts();
        sw_in[0] = 1'b1;
        wait_level(0, 1'b1, lat);
        check_eq("step_lat_ok", int'(lat >= LAT_MIN && lat <= LAT_MAX), 1);
        repeat (20) cycle();
        check_eq("step_one_rise", rise_cnt[0], 1);
        check_eq("step_ch1_quiet", {rise_cnt[1] != 0, sw_out[1]}, 0);

        sw_in[0] = 1'b0;
        wait_level(0, 1'b0, lat);
        check_eq("fall_lat_ok", int'(lat >= LAT_MIN && lat <= LAT_MAX), 1);
        repeat (10) cycle();

        // 3: chatter on ch0, then settle high
        clear_counts();
        for (int k = 0; k < 16; k++) begin
            sw_in[0] = ((k % 2) == 0);
            repeat (12) cycle();
        end
        check_eq("chatter_no_rise", rise_cnt[0], 0);
        check_eq("chatter_level", sw_out[0], 0);
        sw_in[0] = 1'b1;
        wait_level(0, 1'b1, lat);
        check_eq("chatter_lat_ok", int'(lat <= LAT_MAX), 1);
        repeat (30) cycle();
        check_eq("chatter_one_rise", rise_cnt[0], 1);

        // 4: long press on ch1
        sw_in[1] = 1'b1;
        wait_level(1, 1'b1, lat);
        clear_counts();
        long_at = -1;
        for (int k = 1; k <= 120; k++) begin
            cycle();
            if (long_press[1] === 1'b1 && long_at < 0) long_at = k;
        end
        check_eq("long_offset", long_at, LONG_CNT * SAMPLE_DIV);
        check_eq("long_once", long_cnt[1], 1);
        sw_in[1] = 1'b0;
        wait_level(1, 1'b0, lat);
        check_eq("long_fall_lat_ok", int'(lat <= LAT_MAX), 1);

        // short press: released as soon as it is accepted
        repeat (10) cycle();
        clear_counts();
        sw_in[1] = 1'b1;
        wait_level(1, 1'b1, lat);
        sw_in[1] = 1'b0;
        wait_level(1, 1'b0, lat);
        repeat (60) cycle();
        check_eq("short_no_long", long_cnt[1], 0);

        // 5: simultaneous steps, then reset mid-debounce
        sw_in = '0;
        repeat (40) cycle();
        sw_in = 2'b11;
        lat   = 0;
        do begin
            cycle();
            lat++;
        end while (sw_rise === 2'b00 && lat < 60);
        check_eq("sim_rise", sw_rise, 2'b11);
        sw_in = '0;
        repeat (40) cycle();
        sw_in[0] = 1'b1;
        repeat (12) cycle();
        rst = 1'b1;
        cycle();
        rst = 1'b0;
        check_eq("mid_rst_out", {sw_out, sw_rise, sw_fall, long_press}, 0);
        wait_level(0, 1'b1, lat);
        check_eq("post_rst_lat_ok", int'(lat >= LAT_MIN && lat <= LAT_MAX), 1);

        // random traffic with occasional resets
        for (int k = 0; k < 60; k++) begin
            sw_in = N_CH'($urandom_range(0, 3));
            if ($urandom_range(0, 11) == 0) begin
                rst = 1'b1;
                cycle();
                rst = 1'b0;
            end
            repeat ($urandom_range(1, 40)) cycle();
        end
        sw_in = '0;
        repeat (40) cycle();

        // 6: active-low instance
        check_eq("n_rst_out", sw_out_n, 2'b00);
        n_idle     = 1'b0;
        sw_in_n[0] = 1'b0;
        lat        = 0;
        do begin
            cycle();
            lat++;
        end while (sw_out_n[0] !== 1'b1 && lat < 60);
        check_eq("n_lat_ok", int'(lat >= LAT_MIN && lat <= LAT_MAX), 1);
        check_eq("n_rise", sw_rise_n, 2'b01);
        cycle();
        check_eq("n_rise_one_clk", sw_rise_n, 2'b00);
        check_eq("n_level", sw_out_n, 2'b01);

        $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
        $finish;
    end

endmodule
`default_nettype wire
